// File: rtl/monopix_readout_if.sv
// Pixel-side and controller-side signals of the MONOPIX readout core.
//
// Handshake: the controller raises `read` for at least one clk_bx cycle per
// word; every 0->1 transition on `read` requests exactly one 27-bit word,
// which appears on `data_out` MSB first starting four edges after the
// request. `token` is the core's "data available" flag and `freeze` is the
// controller's "hold off new data" flag; neither is qualified by the other.
interface monopix_readout_if #(
  parameter int NCOL = 4,
  parameter int NROW = 8
);
  localparam int NPIX = NCOL * NROW;

  logic              reset_bcid;
  logic [NPIX-1:0]   hit;
  logic [NPIX-1:0]   pix_en;
  logic [NPIX-1:0]   inj_en;
  logic              pulse;
  logic              freeze;
  logic              read;
  logic              token;
  logic              data_out;
  logic [5:0]        bcid_dbg;
  logic [2*NPIX-1:0] state_dbg;

  modport master (
    output reset_bcid, hit, pix_en, inj_en, pulse, freeze, read,
    input  token, data_out, bcid_dbg, state_dbg
  );

  modport slave (
    input  reset_bcid, hit, pix_en, inj_en, pulse, freeze, read,
    output token, data_out, bcid_dbg, state_dbg
  );
endinterface

// File: rtl/monopix_readout.sv
// MONOPIX readout core: per-pixel Gray-coded leading/trailing edge capture,
// token generation and a freeze/read serial word readout.
module monopix_readout #(
  parameter int NCOL = 4,
  parameter int NROW = 8
) (
  input  logic             clk_bx,
  input  logic             reset,
  input  logic             clk_out,
  monopix_readout_if.slave bus
);
  localparam int NPIX = NCOL * NROW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2,
    READY  = 2'd3
  } pix_state_t;

  logic [5:0]      bcid_q;
  logic [5:0]      bcid_d;
  logic [5:0]      ts_gray;

  pix_state_t      st_q [NPIX];
  pix_state_t      st_d [NPIX];
  logic [5:0]      le_q [NPIX];
  logic [5:0]      le_d [NPIX];
  logic [5:0]      te_q [NPIX];
  logic [5:0]      te_d [NPIX];
  logic [NPIX-1:0] hq_q;
  logic [NPIX-1:0] eff_hit;

  logic            read_q;
  logic            rd_start;
  logic            token_q;
  logic            any_ready;

  logic            sel_found;
  int              sel_idx;
  logic [5:0]      sel_col;
  logic [8:0]      sel_row;
  logic [26:0]     word_sel;

  logic [26:0]     word_q;
  logic [4:0]      ph_q;
  logic            ser_act_q;
  logic            data_q;

  // BCID counter next value: free-running, cleared by either reset
  always_comb begin
    bcid_d = bcid_q + 6'd1;
    if (bus.reset_bcid) bcid_d = 6'd0;
    ts_gray = bcid_q ^ (bcid_q >> 1);
  end

  // BCID register
  always_ff @(posedge clk_bx) begin
    if (reset) bcid_q <= 6'd0;
    else       bcid_q <= bcid_d;
  end

  // Effective hit per pixel and read-edge detection
  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
      eff_hit[i] = (bus.hit[i] | (bus.pulse & bus.inj_en[i])) & bus.pix_en[i];
    end
    rd_start = bus.read & ~read_q;
  end

  // Priority select: lowest column first, then lowest row, among READY pixels
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 0;
    sel_col   = 6'd0;
    sel_row   = 9'd0;
    any_ready = 1'b0;
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < NROW; r++) begin
        if (st_q[c*NROW + r] == READY) begin
          any_ready = 1'b1;
          if (!sel_found) begin
            sel_found = 1'b1;
            sel_idx   = c*NROW + r;
            sel_col   = 6'(c);
            sel_row   = 9'(r);
          end
        end
      end
    end
    word_sel = 27'd0;
    if (sel_found) word_sel = {sel_col, sel_row, le_q[sel_idx], te_q[sel_idx]};
  end

  // Pixel FSM next state: edge capture, freeze gating and read clear
  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
      st_d[i] = st_q[i];
      le_d[i] = le_q[i];
      te_d[i] = te_q[i];
      case (st_q[i])
        IDLE: begin
          if (eff_hit[i] && !hq_q[i]) begin
            st_d[i] = ACTIVE;
            le_d[i] = ts_gray;
          end
        end
        ACTIVE: begin
          if (!eff_hit[i] && hq_q[i]) begin
            te_d[i] = ts_gray;
            // An unfrozen falling edge skips straight to READY
            st_d[i] = bus.freeze ? DONE : READY;
          end
        end
        DONE: begin
          if (!bus.freeze) st_d[i] = READY;
        end
        READY: begin
          if (rd_start && sel_found && (sel_idx == i)) st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  // Pixel state, timestamps and hit history registers
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      hq_q <= '0;
      for (int i = 0; i < NPIX; i++) begin
        st_q[i] <= IDLE;
        le_q[i] <= 6'd0;
        te_q[i] <= 6'd0;
      end
    end else begin
      hq_q <= eff_hit;
      for (int i = 0; i < NPIX; i++) begin
        st_q[i] <= st_d[i];
        le_q[i] <= le_d[i];
        te_q[i] <= te_d[i];
      end
    end
  end

  // Read-request history and registered token
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      read_q  <= 1'b0;
      token_q <= 1'b0;
    end else begin
      read_q  <= bus.read;
      token_q <= any_ready;
    end
  end

  // Serializer: latch the word on a read edge, emit bit 26 after the 4th edge
  always_ff @(posedge clk_out) begin
    if (reset) begin
      word_q    <= 27'd0;
      ph_q      <= 5'd0;
      ser_act_q <= 1'b0;
      data_q    <= 1'b0;
    end else if (rd_start) begin
      word_q    <= word_sel;
      ph_q      <= 5'd1;
      ser_act_q <= 1'b1;
      data_q    <= 1'b0;
    end else if (ser_act_q) begin
      ph_q <= ph_q + 5'd1;
      if (ph_q >= 5'd3 && ph_q <= 5'd29) data_q <= word_q[5'd29 - ph_q];
      else                               data_q <= 1'b0;
      if (ph_q == 5'd30) ser_act_q <= 1'b0;
    end
  end

  // Output and debug drive
  always_comb begin
    bus.token    = token_q;
    bus.data_out = data_q;
    bus.bcid_dbg = bcid_q;
    for (int i = 0; i < NPIX; i++) begin
      bus.state_dbg[2*i +: 2] = st_q[i];
    end
  end
endmodule

// File: tb/tb_monopix_readout.sv
// Testbench for monopix_readout: directed scenarios plus randomized hits,
// freezes and reads, checked cycle by cycle against a timestamp-based model.
module tb_monopix_readout;
  localparam int NCOL = 4;
  localparam int NROW = 8;
  localparam int NPIX = NCOL * NROW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  monopix_readout_if #(.NCOL(NCOL), .NROW(NROW)) bus ();

  monopix_readout #(.NCOL(NCOL), .NROW(NROW)) dut (
    .clk_bx  (clk),
    .reset   (reset),
    .clk_out (clk),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [26:0] exp_q[$];

  // Reference model: each pixel remembers when its pulse began/ended (binary
  // BCID), whether it still waits for an unfrozen cycle, and whether it is
  // available to a read.
  logic            m_busy [NPIX];
  logic            m_pend [NPIX];
  logic            m_rdy  [NPIX];
  logic            m_hq   [NPIX];
  logic [5:0]      m_le   [NPIX];
  logic [5:0]      m_te   [NPIX];
  logic [5:0]      m_bcid;
  logic            m_read_prev;
  int              ser_j;
  logic [26:0]     ser_word;
  logic            exp_tok;
  logic            exp_dout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] gray6(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] ungray6(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int k = 4; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  // Advance one clk_bx edge: update the model from the inputs the DUT will
  // sample, then compare the DUT outputs just after the edge.
  task automatic step();
    logic        rd_edge;
    logic        found;
    logic        eff;
    logic [26:0] word;
    logic        rdy_old [NPIX];
    if (reset) begin
      for (int i = 0; i < NPIX; i++) begin
        m_busy[i] = 0; m_pend[i] = 0; m_rdy[i] = 0; m_hq[i] = 0;
        m_le[i] = 0; m_te[i] = 0;
      end
      m_bcid = 0; m_read_prev = 0; ser_j = 40; ser_word = 0;
      exp_tok = 0; exp_dout = 0;
    end else begin
      exp_tok = 0;
      for (int i = 0; i < NPIX; i++) begin
        rdy_old[i] = m_rdy[i];
        if (m_rdy[i]) exp_tok = 1;
      end
      rd_edge = bus.read && !m_read_prev;
      if (rd_edge) begin
        word = 0; found = 0;
        for (int i = 0; i < NPIX; i++) begin
          if (!found && m_rdy[i]) begin
            found = 1;
            word = {6'(i / NROW), 9'(i % NROW), gray6(m_le[i]), gray6(m_te[i])};
            m_rdy[i] = 0;
          end
        end
        exp_q.push_back(word);
        ser_word = word;
        ser_j = 1;
      end else if (ser_j < 40) begin
        ser_j++;
      end
      for (int i = 0; i < NPIX; i++) begin
        eff = (bus.hit[i] | (bus.pulse & bus.inj_en[i])) & bus.pix_en[i];
        if (m_busy[i]) begin
          if (!eff && m_hq[i]) begin
            m_busy[i] = 0; m_te[i] = m_bcid; m_pend[i] = 1;
          end
        end else if (!m_pend[i] && !rdy_old[i]) begin
          if (eff && !m_hq[i]) begin
            m_busy[i] = 1; m_le[i] = m_bcid;
          end
        end
        if (m_pend[i] && !bus.freeze) begin
          m_pend[i] = 0; m_rdy[i] = 1;
        end
        m_hq[i] = eff;
      end
      m_read_prev = bus.read;
      m_bcid = bus.reset_bcid ? 6'd0 : m_bcid + 6'd1;
      exp_dout = (ser_j >= 4 && ser_j <= 30) ? ser_word[30 - ser_j] : 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("token", bus.token, exp_tok);
    check_eq("data_out", bus.data_out, exp_dout);
    check_eq("bcid", bus.bcid_dbg, m_bcid);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- driver tasks ----------------
  // One complete read: request edge, then collect the 27 bits after E4..E30.
  task automatic do_read(output logic [26:0] got);
    logic [26:0] exp;
    exp_q.delete();
    bus.read = 1;
    step();
    bus.read = 0;
    got = 0;
    for (int j = 2; j <= 31; j++) begin
      step();
      if (j >= 4 && j <= 30) got = {got[25:0], bus.data_out};
    end
    if (exp_q.size() == 0) begin
      check_eq("word_queue", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check_eq("word", got, exp);
    end
  endtask

  task automatic drain();
    logic [26:0] w;
    for (int k = 0; k < 40 && exp_tok; k++) do_read(w);
    check_eq("drained_token", bus.token, 0);
  endtask

  task automatic wait_bcid(input logic [5:0] b);
    for (int k = 0; k < 70 && m_bcid != b; k++) step();
    check_eq("bcid_reach", m_bcid, b);
  endtask

  // ---------------- stimulus ----------------
  logic [26:0] w;
  logic [5:0]  le_b, te_b;

  initial begin
    reset = 1;
    bus.reset_bcid = 0; bus.hit = '0; bus.pix_en = '1; bus.inj_en = '0;
    bus.pulse = 0; bus.freeze = 0; bus.read = 0;
    steps(3);
    check_eq("rst_token", bus.token, 0);
    check_eq("rst_dout", bus.data_out, 0);
    reset = 0;

    // BCID clear held three cycles, then counting from 0
    bus.reset_bcid = 1;
    steps(3);
    check_eq("bcid_clr", bus.bcid_dbg, 0);
    bus.reset_bcid = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("bcid_cnt", bus.bcid_dbg, k);
    end
    check_eq("idle_token", bus.token, 0);

    // Pixel (0,0) high for BCID 5..13, low at 14
    wait_bcid(6'd5);
    bus.hit[0] = 1;
    steps(9);
    bus.hit[0] = 0;
    step();
    step();
    check_eq("p00_token", bus.token, 1);
    do_read(w);
    check_eq("p00_col", w[26:21], 0);
    check_eq("p00_row", w[20:12], 0);
    check_eq("p00_le", ungray6(w[11:6]), 5);
    check_eq("p00_te", ungray6(w[5:0]), 14);

    // Two READY pixels: lowest column first
    bus.hit[0] = 1; bus.hit[2*NROW+7] = 1;
    steps(2);
    bus.hit = '0;
    steps(3);
    do_read(w);
    check_eq("two_first_col", w[26:21], 0);
    check_eq("two_token_held", bus.token, 1);
    do_read(w);
    check_eq("two_second_col", w[26:21], 2);
    check_eq("two_second_row", w[20:12], 7);
    check_eq("two_token_low", bus.token, 0);

    // Freeze holds a finished hit back from READY
    bus.freeze = 1;
    bus.hit[1*NROW+1] = 1;
    steps(3);
    bus.hit[1*NROW+1] = 0;
    steps(4);
    check_eq("frz_token", bus.token, 0);
    bus.freeze = 0;
    step();
    check_eq("frz_release_same", bus.token, 0);
    step();
    check_eq("frz_release_next", bus.token, 1);
    do_read(w);
    check_eq("frz_row", w[20:12], 1);

    // Injection pulse of four cycles on (1,3)
    bus.inj_en[1*NROW+3] = 1;
    bus.pulse = 1;
    steps(4);
    bus.pulse = 0;
    steps(2);
    do_read(w);
    check_eq("inj_col", w[26:21], 1);
    check_eq("inj_row", w[20:12], 3);
    check_eq("inj_len", 6'(ungray6(w[5:0]) - ungray6(w[11:6])), 4);
    bus.pix_en[1*NROW+3] = 0;
    bus.pulse = 1;
    steps(4);
    bus.pulse = 0;
    steps(3);
    check_eq("inj_masked", bus.token, 0);
    bus.pix_en = '1; bus.inj_en = '0;

    // BCID wrap inside a hit
    wait_bcid(6'd62);
    bus.hit[3*NROW] = 1;
    steps(4);
    bus.hit[3*NROW] = 0;
    steps(2);
    do_read(w);
    le_b = ungray6(w[11:6]);
    te_b = ungray6(w[5:0]);
    check_eq("wrap_le", le_b, 62);
    check_eq("wrap_te", te_b, 2);

    // Read with nothing READY
    do_read(w);
    check_eq("empty_word", w, 0);
    check_eq("empty_token", bus.token, 0);

    // Reset in the middle of serialization
    bus.hit[5] = 1;
    steps(2);
    bus.hit[5] = 0;
    bus.hit[6] = 1;
    steps(2);
    bus.hit[6] = 0;
    steps(2);
    bus.read = 1;
    step();
    bus.read = 0;
    steps(8);
    reset = 1;
    step();
    check_eq("midrst_token", bus.token, 0);
    check_eq("midrst_dout", bus.data_out, 0);
    check_eq("midrst_bcid", bus.bcid_dbg, 0);
    check_eq("midrst_state", bus.state_dbg, 0);
    reset = 0;
    steps(3);

    // Randomized hits, injections, freezes and overlapping reads
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NPIX; i++) begin
        if ($urandom_range(0, 99) < 3) bus.hit[i] = ~bus.hit[i];
      end
      if ($urandom_range(0, 99) < 2) bus.inj_en = NPIX'($urandom);
      if ($urandom_range(0, 99) < 5) bus.pulse = ~bus.pulse;
      if ($urandom_range(0, 99) < 2) bus.pix_en = NPIX'($urandom) | NPIX'($urandom);
      if ($urandom_range(0, 99) < 10) bus.freeze = ~bus.freeze;
      if ($urandom_range(0, 99) < 8) bus.read = ~bus.read;
      if ($urandom_range(0, 999) < 3) bus.reset_bcid = 1;
      else                            bus.reset_bcid = 0;
      step();
    end
    bus.hit = '0; bus.pulse = 0; bus.freeze = 0; bus.read = 0;
    bus.reset_bcid = 0; bus.pix_en = '1;
    steps(40);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
